// File: rtl/morse_seq_gen.sv
// morse_seq_gen: keys a latched dot/dash pattern onto Pin_Out with Morse unit timing.
//   Parameters: CLK_FREQ_HZ (CLK rate), UNIT_MS (dot length in ms), MAX_SYM (max symbols)
//   Inputs : CLK, RST_N (async, active-low), Start, Abort, Sym_Len[4:0],
//            Sym_Pat[MAX_SYM-1:0] (bit k=1 dash, bit 0 sent first),
//            Repeat (only when MORSE_SEQ_GEN_REPEAT_EN is defined)
//   Outputs: Pin_Out (registered key, 1 = mark), Busy (not IDLE), Done (1-cycle completion pulse)
//   Macro  : MORSE_SEQ_GEN_REPEAT_EN adds the Repeat input (loop the message at end of TAIL)
module morse_seq_gen #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int UNIT_MS     = 100,
    parameter int MAX_SYM     = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               Start,
    input  logic               Abort,
    input  logic [4:0]         Sym_Len,
    input  logic [MAX_SYM-1:0] Sym_Pat,
`ifdef MORSE_SEQ_GEN_REPEAT_EN
    input  logic               Repeat,
`endif
    output logic               Pin_Out,
    output logic               Busy,
    output logic               Done
);
    localparam int PRE_N = CLK_FREQ_HZ / 1000;
    localparam int PRE_W = PRE_N > 1 ? $clog2(PRE_N) : 1;

    typedef enum logic [1:0] {IDLE, MARK, GAP, TAIL} state_t;

    state_t             state;
    logic [PRE_W-1:0]   pre;
    logic [9:0]         ms_cnt;
    logic [1:0]         unit_cnt;
    logic [4:0]         len;
    logic [4:0]         idx;
    logic [MAX_SYM-1:0] pat;
    logic [MAX_SYM-1:0] cur;
    logic [4:0]         len_sel;
    logic [1:0]         last_unit;
    logic               ms_tick;
    logic               unit_tick;
    logic               span_end;
    logic               rep;

`ifdef MORSE_SEQ_GEN_REPEAT_EN
    assign rep = Repeat;
`else
    assign rep = 1'b0;
`endif

    assign cur       = pat >> idx;
    assign len_sel   = (Sym_Len > 5'(MAX_SYM)) ? 5'(MAX_SYM) : Sym_Len;
    assign ms_tick   = pre == PRE_W'(PRE_N - 1);
    assign unit_tick = ms_tick && ms_cnt == 10'(UNIT_MS - 1);
    // Index of the final unit of the current interval: dash and TAIL last 3 units, the rest 1.
    assign last_unit = ((state == MARK && cur[0]) || state == TAIL) ? 2'd2 : 2'd0;
    assign span_end  = unit_tick && unit_cnt == last_unit;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            Pin_Out  <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            pre      <= '0;
            ms_cnt   <= '0;
            unit_cnt <= '0;
            len      <= '0;
            idx      <= '0;
            pat      <= '0;
        end else begin
            Done <= 1'b0;
            // Abort also blocks a Start presented in the same cycle.
            if (Abort) begin
                state   <= IDLE;
                Pin_Out <= 1'b0;
                Busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (Start) begin
                        if (Sym_Len != 5'd0) begin
                            pat     <= Sym_Pat;
                            len     <= len_sel;
                            idx     <= '0;
                            state   <= MARK;
                            Pin_Out <= 1'b1;
                            Busy    <= 1'b1;
                        end else begin
                            Done <= 1'b1;
                        end
                    end
                    MARK: if (span_end) begin
                        Pin_Out <= 1'b0;
                        state   <= (idx + 5'd1 < len) ? GAP : TAIL;
                    end
                    GAP: if (span_end) begin
                        idx     <= idx + 5'd1;
                        Pin_Out <= 1'b1;
                        state   <= MARK;
                    end
                    TAIL: if (span_end) begin
                        if (rep) begin
                            idx     <= '0;
                            Pin_Out <= 1'b1;
                            state   <= MARK;
                        end else begin
                            state <= IDLE;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end
                    end
                endcase
            end
            // Timebase restarts on every state change so each interval is cycle-exact.
            if (Abort || state == IDLE || span_end) begin
                pre      <= '0;
                ms_cnt   <= '0;
                unit_cnt <= '0;
            end else begin
                pre <= ms_tick ? '0 : pre + 1'b1;
                if (ms_tick)
                    ms_cnt <= unit_tick ? 10'd0 : ms_cnt + 10'd1;
                if (unit_tick)
                    unit_cnt <= unit_cnt + 2'd1;
            end
        end
    end
endmodule
